// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction-memory address/data, redirect request from ID,
// and the show-ahead dequeue handshake toward the IF/ID register.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic [31:0]              ImemAddr;
  logic [31:0]              ImemData;
  logic                     Redirect;
  logic [31:0]              RedirectPC;
  logic                     DeqReady;
  logic                     DeqValid;
  logic [31:0]              DeqInstr;
  logic [31:0]              DeqPCAdd;
  logic [$clog2(DEPTH):0]   Count;

  // Queue side
  modport slave (
    output ImemAddr,
    input  ImemData,
    input  Redirect,
    input  RedirectPC,
    input  DeqReady,
    output DeqValid,
    output DeqInstr,
    output DeqPCAdd,
    output Count
  );

  // Environment side (memory, ID stage, decode)
  modport master (
    input  ImemAddr,
    output ImemData,
    output Redirect,
    output RedirectPC,
    output DeqReady,
    input  DeqValid,
    input  DeqInstr,
    input  DeqPCAdd,
    input  Count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue feeding the IF/ID register.
// Owns the fetch PC, captures {ImemData, PC+4} each cycle into a small FIFO,
// and presents the oldest entry show-ahead. Redirect flushes and restarts.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          Clk,
  input  logic          Rst,
  fetch_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_pc;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_pcadd [DEPTH];

  logic          w_full;
  logic          w_valid;
  logic          w_deq;
  logic          w_enq;
  logic [31:0]   w_pc_plus4;
  logic [31:0]   w_target;

  // Full/empty come from the occupancy counter, never from pointer compare.
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_valid    = (r_count != '0);
  assign w_deq      = w_valid & bus.DeqReady;
  // A full queue can still enqueue when the head leaves in the same cycle.
  assign w_enq      = !bus.Redirect & (!w_full | w_deq);
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = bus.RedirectPC & 32'hFFFF_FFFC;

  assign bus.ImemAddr = r_pc;
  assign bus.DeqValid = w_valid;
  assign bus.DeqInstr = r_instr[r_rd_ptr];
  assign bus.DeqPCAdd = r_pcadd[r_rd_ptr];
  assign bus.Count    = r_count;

  // Fetch PC, pointers and occupancy; redirect overrides enqueue and dequeue.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.Redirect) begin
      r_pc     <= w_target;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_pc     <= w_pc_plus4;
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end

  // Entry storage: word and its PC+4 written at the write pointer.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pcadd[i] <= '0;
      end
    end else if (w_enq) begin
      r_instr[r_wr_ptr] <= bus.ImemData;
      r_pcadd[r_wr_ptr] <= w_pc_plus4;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a scoreboard of expected head entries.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcadd;
  } ent_t;

  logic Clk;
  logic Rst;
  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  int          passed = 0;
  int          total  = 0;
  ent_t        sb[$];
  logic [31:0] m_pc;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign bus.ImemData = imem(bus.ImemAddr);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(bus.Count), 32'(sb.size()));
    chk({tag, ".valid"}, 32'(bus.DeqValid), 32'(sb.size() != 0));
    chk({tag, ".addr"}, bus.ImemAddr, m_pc);
    if (sb.size() != 0) begin
      chk({tag, ".instr"}, bus.DeqInstr, sb[0].instr);
      chk({tag, ".pcadd"}, bus.DeqPCAdd, sb[0].pcadd);
    end
  endtask

  // One clock edge: update the model from the inputs in force, then check.
  task automatic cycle(input string tag);
    logic deq, enq;
    deq = (sb.size() != 0) && bus.DeqReady;
    enq = !bus.Redirect && ((sb.size() < DEPTH) || deq);
    @(posedge Clk);
    if (bus.Redirect) begin
      sb.delete();
      m_pc = {bus.RedirectPC[31:2], 2'b00};
    end else begin
      if (deq) void'(sb.pop_front());
      if (enq) begin
        sb.push_back('{instr: imem(m_pc), pcadd: m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    sb.delete();
    m_pc = RESET_PC;
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  initial begin
    Rst            = 1'b0;
    bus.Redirect   = 1'b0;
    bus.RedirectPC = '0;
    bus.DeqReady   = 1'b0;
    m_pc           = RESET_PC;

    // Reset state
    #2;
    chk("rst.count", 32'(bus.Count), 32'd0);
    chk("rst.valid", 32'(bus.DeqValid), 32'd0);
    chk("rst.instr", bus.DeqInstr, 32'd0);
    chk("rst.pcadd", bus.DeqPCAdd, 32'd0);
    chk("rst.addr", bus.ImemAddr, RESET_PC);

    // Startup streaming with DeqReady=1
    @(negedge Clk);
    Rst = 1'b1;
    bus.DeqReady = 1'b1;
    #1;
    chk("c0.valid", 32'(bus.DeqValid), 32'd0);
    chk("c0.addr", bus.ImemAddr, 32'd0);
    cycle("e1");
    chk("e1.instr", bus.DeqInstr, 32'h1000_0000);
    chk("e1.pcadd", bus.DeqPCAdd, 32'd4);
    cycle("e2");
    chk("e2.pcadd", bus.DeqPCAdd, 32'd8);
    cycle("e3");
    chk("e3.instr", bus.DeqInstr, 32'h1000_0002);

    // Fill from reset, then drain
    do_reset();
    bus.DeqReady = 1'b0;
    for (int i = 0; i < 6; i++) cycle("fill");
    chk("fill.count", 32'(bus.Count), 32'd4);
    chk("fill.addr", bus.ImemAddr, 32'h10);
    chk("fill.head", bus.DeqPCAdd, 32'd4);
    bus.DeqReady = 1'b1;
    cycle("pop1");
    chk("pop1.pcadd", bus.DeqPCAdd, 32'd8);
    chk("pop1.count", 32'(bus.Count), 32'd4);
    cycle("pop2");
    chk("pop2.pcadd", bus.DeqPCAdd, 32'd12);
    cycle("pop3");
    chk("pop3.pcadd", bus.DeqPCAdd, 32'd16);

    // Redirect with Count=3
    do_reset();
    bus.DeqReady = 1'b0;
    for (int i = 0; i < 3; i++) cycle("pre3");
    chk("pre3.count", 32'(bus.Count), 32'd3);
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'h0000_0043;
    cycle("redir");
    bus.Redirect = 1'b0;
    chk("redir.count", 32'(bus.Count), 32'd0);
    chk("redir.valid", 32'(bus.DeqValid), 32'd0);
    chk("redir.addr", bus.ImemAddr, 32'h40);
    cycle("redir1");
    chk("redir1.pcadd", bus.DeqPCAdd, 32'h44);

    // Redirect on a full queue while dequeuing
    for (int i = 0; i < 5; i++) cycle("full");
    chk("full.count", 32'(bus.Count), 32'd4);
    bus.DeqReady   = 1'b1;
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'h0000_0200;
    cycle("rfull");
    bus.Redirect = 1'b0;
    chk("rfull.count", 32'(bus.Count), 32'd0);
    chk("rfull.addr", bus.ImemAddr, 32'h200);
    cycle("rfull1");
    chk("rfull1.pcadd", bus.DeqPCAdd, 32'h204);

    // Back-to-back redirects: only the last target is fetched
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'h0000_0300;
    cycle("b2b0");
    bus.RedirectPC = 32'h0000_0402;
    cycle("b2b1");
    bus.Redirect = 1'b0;
    chk("b2b.addr", bus.ImemAddr, 32'h400);
    cycle("b2b2");
    chk("b2b.pcadd", bus.DeqPCAdd, 32'h404);

    // Asynchronous reset between edges with Count=2
    bus.DeqReady = 1'b0;
    bus.Redirect = 1'b1;
    bus.RedirectPC = 32'h0000_0800;
    cycle("ar0");
    bus.Redirect = 1'b0;
    cycle("ar1");
    cycle("ar2");
    chk("ar.count2", 32'(bus.Count), 32'd2);
    #1;
    Rst = 1'b0;
    #1;
    chk("ar.valid", 32'(bus.DeqValid), 32'd0);
    chk("ar.addr", bus.ImemAddr, RESET_PC);
    chk("ar.count", 32'(bus.Count), 32'd0);
    sb.delete();
    m_pc = RESET_PC;
    @(negedge Clk);
    Rst = 1'b1;

    // PC wrap at 2^32
    bus.DeqReady   = 1'b1;
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'hFFFF_FFF8;
    cycle("wr0");
    bus.Redirect = 1'b0;
    cycle("wr1");
    chk("wr1.pcadd", bus.DeqPCAdd, 32'hFFFF_FFFC);
    cycle("wr2");
    chk("wr2.pcadd", bus.DeqPCAdd, 32'h0000_0000);
    cycle("wr3");
    chk("wr3.pcadd", bus.DeqPCAdd, 32'h0000_0004);

    // Random consumer stalls: pointer wrap and ordering against the scoreboard
    for (int i = 0; i < 60; i++) begin
      bus.DeqReady = 1'($urandom_range(0, 1));
      bus.Redirect = ($urandom_range(0, 19) == 0);
      bus.RedirectPC = $urandom;
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
